// File: rtl/lc3_control_fsm.sv
// LC-3 control sequencer: Moore FSM producing every datapath load, gate and mux select.
// Opcode and IR_11 come from IR, which stays stable for the whole instruction, so shared states branch on them.
module lc3_control_fsm #(
  parameter bit RESET_STATE_HALT = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic [3:0] Opcode,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       MEM_R,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_REG,
  output logic       LD_CC,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] PCMUX,
  output logic [1:0] DRMUX,
  output logic [1:0] SR1MUX,
  output logic [1:0] MARMUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       R_W,
  output logic       Halted,
  output logic [4:0] State
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [4:0] {
    S_HALTED    = 5'd0,
    S_FETCH_MAR = 5'd1,
    S_FETCH_MEM = 5'd2,
    S_FETCH_IR  = 5'd3,
    S_DECODE    = 5'd4,
    S_ADD       = 5'd5,
    S_AND       = 5'd6,
    S_NOT       = 5'd7,
    S_BR_TAKEN  = 5'd8,
    S_JMP       = 5'd9,
    S_JSR_LINK  = 5'd10,
    S_JSR_OFF   = 5'd11,
    S_JSR_REG   = 5'd12,
    S_LEA       = 5'd13,
    S_ADDR_PC9  = 5'd14,
    S_ADDR_REG6 = 5'd15,
    S_MEM_READ  = 5'd16,
    S_IND_MAR   = 5'd17,
    S_MEM_READ2 = 5'd18,
    S_LD_WB     = 5'd19,
    S_ST_DATA   = 5'd20,
    S_MEM_WRITE = 5'd21,
    S_TRAP_MAR  = 5'd22,
    S_TRAP_PC   = 5'd23
  } state_t;

  localparam state_t RESET_STATE = RESET_STATE_HALT ? S_HALTED : S_FETCH_MAR;

  state_t state_q, state_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALTED:    if (Run) state_d = S_FETCH_MAR;
      S_FETCH_MAR: state_d = S_FETCH_MEM;
      S_FETCH_MEM: if (MEM_R) state_d = S_FETCH_IR;
      S_FETCH_IR:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD:                        state_d = S_ADD;
          OP_AND:                        state_d = S_AND;
          OP_NOT:                        state_d = S_NOT;
          OP_BR:                         state_d = BEN ? S_BR_TAKEN : S_FETCH_MAR;
          OP_JMP:                        state_d = S_JMP;
          OP_JSR:                        state_d = S_JSR_LINK;
          OP_LEA:                        state_d = S_LEA;
          OP_LD, OP_LDI, OP_ST, OP_STI:  state_d = S_ADDR_PC9;
          OP_LDR, OP_STR:                state_d = S_ADDR_REG6;
          OP_TRAP:                       state_d = S_TRAP_MAR;
          default:                       state_d = S_HALTED;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR_OFF, S_JSR_REG, S_LEA, S_LD_WB, S_TRAP_PC:
        state_d = S_FETCH_MAR;
      // Direct stores already hold their final address in MAR; everything else reads first.
      S_ADDR_PC9, S_ADDR_REG6:
        state_d = (Opcode == OP_ST || Opcode == OP_STR) ? S_ST_DATA : S_MEM_READ;
      S_TRAP_MAR:  state_d = S_MEM_READ;
      S_MEM_READ: begin
        if (MEM_R) begin
          case (Opcode)
            OP_LD, OP_LDR:  state_d = S_LD_WB;
            OP_LDI, OP_STI: state_d = S_IND_MAR;
            OP_TRAP:        state_d = S_JSR_LINK;
            default:        state_d = S_FETCH_MAR;
          endcase
        end
      end
      S_IND_MAR:   state_d = (Opcode == OP_STI) ? S_ST_DATA : S_MEM_READ2;
      S_MEM_READ2: if (MEM_R) state_d = S_LD_WB;
      S_JSR_LINK: begin
        if (Opcode == OP_TRAP) state_d = S_TRAP_PC;
        else if (IR_11)        state_d = S_JSR_OFF;
        else                   state_d = S_JSR_REG;
      end
      S_ST_DATA:   state_d = S_MEM_WRITE;
      S_MEM_WRITE: if (MEM_R) state_d = S_FETCH_MAR;
      default:     state_d = S_HALTED;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_REG     = 1'b0;
    LD_CC      = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    PCMUX      = 2'b00;
    DRMUX      = 2'b00;
    SR1MUX     = 2'b00;
    MARMUX     = 2'b00;
    ALUK       = 2'b00;
    MIO_EN     = 1'b0;
    R_W        = 1'b0;
    Halted     = 1'b0;
    unique case (state_q)
      S_HALTED:    Halted = 1'b1;
      S_FETCH_MAR: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
      S_FETCH_MEM, S_MEM_READ, S_MEM_READ2: begin MIO_EN = 1'b1; LD_MDR = 1'b1; end
      S_FETCH_IR:  begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_DECODE:    LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        SR1MUX = 2'b01; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (state_q == S_AND) ? 2'b01 : (state_q == S_NOT) ? 2'b10 : 2'b00;
      end
      S_BR_TAKEN:  begin ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1; end
      S_JMP, S_JSR_REG: begin SR1MUX = 2'b01; ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
      S_JSR_LINK:  begin GatePC = 1'b1; DRMUX = 2'b01; LD_REG = 1'b1; end
      S_JSR_OFF:   begin ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1; end
      S_LEA:       begin GateMARMUX = 1'b1; ADDR2MUX = 2'b10; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_ADDR_PC9:  begin GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR2MUX = 2'b10; end
      S_ADDR_REG6: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; SR1MUX = 2'b01; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
      end
      S_IND_MAR:   begin GateMDR = 1'b1; LD_MAR = 1'b1; end
      S_LD_WB:     begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      // Store data passes SR (IR[11:9]) through the ALU so MDR loads from the bus, not memory.
      S_ST_DATA:   begin ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_MEM_WRITE: R_W = 1'b1;
      S_TRAP_MAR:  begin GateMARMUX = 1'b1; MARMUX = 2'b01; LD_MAR = 1'b1; end
      S_TRAP_PC:   begin GateMDR = 1'b1; PCMUX = 2'b01; LD_PC = 1'b1; end
      default:     Halted = 1'b0;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: walks each instruction class and compares the full control word every cycle.
module tb_lc3_control_fsm;

  typedef logic [26:0] ctl_t;

  logic       Clk = 1'b0;
  logic       Reset, Run, IR_11, BEN, MEM_R;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX, ADDR1MUX;
  logic [1:0] ADDR2MUX, PCMUX, DRMUX, SR1MUX, MARMUX, ALUK;
  logic       MIO_EN, R_W, Halted;
  logic [4:0] State;
  ctl_t       ctl;

  int total = 0;
  int bad = 0;

  lc3_control_fsm #(.RESET_STATE_HALT(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Opcode(Opcode), .IR_11(IR_11), .BEN(BEN), .MEM_R(MEM_R),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_REG(LD_REG),
    .LD_CC(LD_CC), .LD_PC(LD_PC), .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .PCMUX(PCMUX),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .MARMUX(MARMUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
    .R_W(R_W), .Halted(Halted), .State(State)
  );

  always #5 Clk = ~Clk;

  assign ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC, GatePC, GateMDR, GateALU,
                GateMARMUX, ADDR1MUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, MARMUX, ALUK,
                MIO_EN, R_W, Halted};

  // Single-bit fields of the packed control word
  localparam ctl_t K_LD_MAR  = 27'd1 << 26;
  localparam ctl_t K_LD_MDR  = 27'd1 << 25;
  localparam ctl_t K_LD_IR   = 27'd1 << 24;
  localparam ctl_t K_LD_BEN  = 27'd1 << 23;
  localparam ctl_t K_LD_REG  = 27'd1 << 22;
  localparam ctl_t K_LD_CC   = 27'd1 << 21;
  localparam ctl_t K_LD_PC   = 27'd1 << 20;
  localparam ctl_t K_GPC     = 27'd1 << 19;
  localparam ctl_t K_GMDR    = 27'd1 << 18;
  localparam ctl_t K_GALU    = 27'd1 << 17;
  localparam ctl_t K_GMARMUX = 27'd1 << 16;
  localparam ctl_t K_A1_SR1  = 27'd1 << 15;
  localparam ctl_t K_MIO     = 27'd1 << 2;
  localparam ctl_t K_RW      = 27'd1 << 1;
  localparam ctl_t K_HALTED  = 27'd1;
  // Multi-bit mux codes
  localparam ctl_t A2_OFF6   = 27'd1 << 13;
  localparam ctl_t A2_OFF9   = 27'd2 << 13;
  localparam ctl_t A2_OFF11  = 27'd3 << 13;
  localparam ctl_t PC_BUS    = 27'd1 << 11;
  localparam ctl_t PC_ADDER  = 27'd2 << 11;
  localparam ctl_t DR_R7     = 27'd1 << 9;
  localparam ctl_t SR1_86    = 27'd1 << 7;
  localparam ctl_t MAR_ZEXT  = 27'd1 << 5;
  localparam ctl_t ALU_AND   = 27'd1 << 3;
  localparam ctl_t ALU_NOT   = 27'd2 << 3;
  localparam ctl_t ALU_PASS  = 27'd3 << 3;

  localparam ctl_t E_HALTED  = K_HALTED;
  localparam ctl_t E_FMAR    = K_GPC | K_LD_MAR | K_LD_PC;
  localparam ctl_t E_FMEM    = K_MIO | K_LD_MDR;
  localparam ctl_t E_FIR     = K_GMDR | K_LD_IR;
  localparam ctl_t E_DEC     = K_LD_BEN;
  localparam ctl_t E_ADD     = SR1_86 | K_GALU | K_LD_REG | K_LD_CC;
  localparam ctl_t E_AND     = E_ADD | ALU_AND;
  localparam ctl_t E_NOT     = E_ADD | ALU_NOT;
  localparam ctl_t E_BR      = A2_OFF9 | PC_ADDER | K_LD_PC;
  localparam ctl_t E_JMP     = SR1_86 | K_A1_SR1 | PC_ADDER | K_LD_PC;
  localparam ctl_t E_LINK    = K_GPC | DR_R7 | K_LD_REG;
  localparam ctl_t E_JSR_OFF = A2_OFF11 | PC_ADDER | K_LD_PC;
  localparam ctl_t E_JSR_REG = SR1_86 | K_A1_SR1 | PC_ADDER | K_LD_PC;
  localparam ctl_t E_LEA     = K_GMARMUX | A2_OFF9 | K_LD_REG | K_LD_CC;
  localparam ctl_t E_APC9    = K_GMARMUX | K_LD_MAR | A2_OFF9;
  localparam ctl_t E_AREG6   = K_GMARMUX | K_LD_MAR | SR1_86 | K_A1_SR1 | A2_OFF6;
  localparam ctl_t E_MREAD   = K_MIO | K_LD_MDR;
  localparam ctl_t E_IND     = K_GMDR | K_LD_MAR;
  localparam ctl_t E_LDWB    = K_GMDR | K_LD_REG | K_LD_CC;
  localparam ctl_t E_STD     = ALU_PASS | K_GALU | K_LD_MDR;
  localparam ctl_t E_MWR     = K_RW;
  localparam ctl_t E_TMAR    = K_GMARMUX | MAR_ZEXT | K_LD_MAR;
  localparam ctl_t E_TPC     = K_GMDR | PC_BUS | K_LD_PC;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulse reset away from the clock edge, then start the FSM so the current sample is FETCH_MAR.
  task automatic start_fetch();
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
    Run = 1'b1;
    tick();
    Run = 1'b0;
  endtask

  task automatic test_reset();
    if (ctl !== E_HALTED) begin
      bad++; $display("[TB] FAIL reset_state: got %h want %h", ctl, E_HALTED);
    end
    total++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ctl !== E_HALTED) begin
        bad++; $display("[TB] FAIL halted_hold cycle %0d: got %h want %h", i, ctl, E_HALTED);
      end
      total++;
    end
    Run = 1'b1;
    tick();
    Run = 1'b0;
    if (ctl !== E_FMAR) begin
      bad++; $display("[TB] FAIL run_start: got %h want %h", ctl, E_FMAR);
    end
    total++;
    #2;
    Reset = 1'b1;
    #1;
    if (ctl !== E_HALTED) begin
      bad++; $display("[TB] FAIL reset_midcycle: got %h want %h", ctl, E_HALTED);
    end
    total++;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_alu();
    ctl_t seq[$];
    logic [3:0] ops [3] = '{4'b0001, 4'b0101, 4'b1001};
    ctl_t exe [3] = '{E_ADD, E_AND, E_NOT};
    for (int k = 0; k < 3; k++) begin
      Opcode = ops[k];
      MEM_R = 1'b1;
      seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, exe[k], E_FMAR};
      start_fetch();
      for (int i = 0; i < seq.size(); i++) begin
        if (i > 0) tick();
        if (ctl !== seq[i]) begin
          bad++; $display("[TB] FAIL alu op=%b cycle %0d: got %h want %h", ops[k], i, ctl, seq[i]);
        end
        total++;
      end
    end
  endtask

  task automatic test_ld_stall();
    ctl_t seq[$];
    logic [13:0] mr = 14'h0810;
    Opcode = 4'b0010;
    seq = '{E_FMAR, E_FMEM, E_FMEM, E_FMEM, E_FMEM, E_FIR, E_DEC, E_APC9,
            E_MREAD, E_MREAD, E_MREAD, E_MREAD, E_LDWB, E_FMAR};
    start_fetch();
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick();
      if (ctl !== seq[i]) begin
        bad++; $display("[TB] FAIL ld_stall cycle %0d: got %h want %h", i, ctl, seq[i]);
      end
      total++;
      MEM_R = mr[i];
    end
  endtask

  task automatic test_branch();
    ctl_t seq[$];
    Opcode = 4'b0000;
    MEM_R = 1'b1;
    for (int b = 0; b < 2; b++) begin
      BEN = b[0];
      if (b == 0) seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_FMAR};
      else        seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_BR, E_FMAR};
      start_fetch();
      for (int i = 0; i < seq.size(); i++) begin
        if (i > 0) tick();
        if (ctl !== seq[i]) begin
          bad++; $display("[TB] FAIL branch ben=%0d cycle %0d: got %h want %h", b, i, ctl, seq[i]);
        end
        total++;
      end
    end
    BEN = 1'b0;
  endtask

  task automatic test_control_flow();
    ctl_t seq[$];
    logic [3:0] ops [5] = '{4'b1111, 4'b0100, 4'b0100, 4'b1100, 4'b1110};
    MEM_R = 1'b1;
    for (int k = 0; k < 5; k++) begin
      Opcode = ops[k];
      IR_11 = (k == 1);
      case (k)
        0: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_TMAR, E_MREAD, E_LINK, E_TPC, E_FMAR};
        1: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_LINK, E_JSR_OFF, E_FMAR};
        2: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_LINK, E_JSR_REG, E_FMAR};
        3: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_JMP, E_FMAR};
        default: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_LEA, E_FMAR};
      endcase
      start_fetch();
      for (int i = 0; i < seq.size(); i++) begin
        if (i > 0) tick();
        if (ctl !== seq[i]) begin
          bad++; $display("[TB] FAIL flow case %0d cycle %0d: got %h want %h", k, i, ctl, seq[i]);
        end
        total++;
      end
    end
    IR_11 = 1'b0;
  endtask

  task automatic test_memory_paths();
    ctl_t seq[$];
    logic [3:0] ops [4] = '{4'b0110, 4'b1010, 4'b0111, 4'b1011};
    MEM_R = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Opcode = ops[k];
      case (k)
        0: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_AREG6, E_MREAD, E_LDWB, E_FMAR};
        1: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_APC9, E_MREAD, E_IND, E_MREAD, E_LDWB, E_FMAR};
        2: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_AREG6, E_STD, E_MWR, E_FMAR};
        default: seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_APC9, E_MREAD, E_IND, E_STD, E_MWR, E_FMAR};
      endcase
      start_fetch();
      for (int i = 0; i < seq.size(); i++) begin
        if (i > 0) tick();
        if (ctl !== seq[i]) begin
          bad++; $display("[TB] FAIL mem op=%b cycle %0d: got %h want %h", ops[k], i, ctl, seq[i]);
        end
        total++;
      end
    end
  endtask

  task automatic test_illegal();
    ctl_t seq[$];
    logic [3:0] ops [2] = '{4'b1101, 4'b1000};
    MEM_R = 1'b1;
    seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_HALTED, E_HALTED, E_HALTED};
    for (int k = 0; k < 2; k++) begin
      Opcode = ops[k];
      start_fetch();
      for (int i = 0; i < seq.size(); i++) begin
        if (i > 0) tick();
        if (ctl !== seq[i]) begin
          bad++; $display("[TB] FAIL illegal op=%b cycle %0d: got %h want %h", ops[k], i, ctl, seq[i]);
        end
        total++;
      end
      Run = 1'b1;
      tick();
      Run = 1'b0;
      if (ctl !== E_FMAR) begin
        bad++; $display("[TB] FAIL illegal_resume op=%b: got %h want %h", ops[k], ctl, E_FMAR);
      end
      total++;
    end
  endtask

  task automatic test_write_reset();
    ctl_t seq[$];
    Opcode = 4'b0011;
    MEM_R = 1'b1;
    seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_APC9, E_STD, E_MWR, E_MWR, E_MWR};
    start_fetch();
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick();
      if (ctl !== seq[i]) begin
        bad++; $display("[TB] FAIL st_stall cycle %0d: got %h want %h", i, ctl, seq[i]);
      end
      total++;
      MEM_R = (i < 5);
    end
    #2;
    Reset = 1'b1;
    #1;
    if (R_W !== 1'b0) begin
      bad++; $display("[TB] FAIL rw_drop: got %b want 0", R_W);
    end
    total++;
    if (ctl !== E_HALTED) begin
      bad++; $display("[TB] FAIL write_reset: got %h want %h", ctl, E_HALTED);
    end
    total++;
    tick();
    Reset = 1'b0;
    MEM_R = 1'b1;
  endtask

  task automatic test_back_to_back();
    ctl_t seq[$];
    Opcode = 4'b0001;
    MEM_R = 1'b1;
    seq = '{E_FMAR, E_FMEM, E_FIR, E_DEC, E_ADD, E_FMAR, E_FMEM, E_FIR, E_DEC, E_AND, E_FMAR};
    start_fetch();
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick();
      if (ctl !== seq[i]) begin
        bad++; $display("[TB] FAIL back_to_back cycle %0d: got %h want %h", i, ctl, seq[i]);
      end
      total++;
      if (i == 5) Opcode = 4'b0101;
    end
  endtask

  initial begin
    Reset = 1'b1;
    Run = 1'b0;
    Opcode = 4'b0000;
    IR_11 = 1'b0;
    BEN = 1'b0;
    MEM_R = 1'b0;
    tick();
    Reset = 1'b0;
    test_reset();
    test_alu();
    test_ld_stall();
    test_branch();
    test_control_flow();
    test_memory_paths();
    test_illegal();
    test_write_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
